// File: rtl/ptw_pkg.sv
// Shared types for the page-table walker: FSM states, port ids, PTE layout.
package ptw_pkg;

  // PTE bit positions
  localparam int PTE_V       = 0;
  localparam int PTE_LEAF    = 1;
  localparam int PTE_PPN_LSB = 12;
  localparam int PTE_PPN_W   = 32 - PTE_PPN_LSB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1_REQ,
    ST_L1_WAIT,
    ST_L0_REQ,
    ST_L0_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic {
    PORT_IMEM = 1'b0,
    PORT_DMEM = 1'b1
  } port_e;

  // Field order matches PTE_* positions (MSB first)
  typedef struct packed {
    logic [PTE_PPN_W-1:0]   ppn;
    logic [PTE_PPN_LSB-3:0] rsvd;
    logic                   leaf;
    logic                   v;
  } pte_t;

  // Registered response bundle toward one TLB
  typedef struct packed {
    logic        valid;
    logic        error;
    logic [31:0] ppn;
  } ptw_resp_t;

endpackage

// File: rtl/ptw_rr_arbiter.sv
// 2-way round-robin arbiter. Grants only while en is high (walker idle), so
// the winner stays locked in until the walk finishes and en returns.
module ptw_rr_arbiter
  import ptw_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,   // [0]=imem, [1]=dmem
  output logic [1:0] gnt
);

  port_e last_q;

  // On a collision the port not served last wins; otherwise the lone requester
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = (last_q == PORT_DMEM) ? 2'b01 : 2'b10;
      else      gnt = req;
    end
  end

  // Remember who was served; dmem counts as last after reset so imem goes first
  always_ff @(posedge clk) begin
    if (reset)       last_q <= PORT_DMEM;
    else if (gnt[0]) last_q <= PORT_IMEM;
    else if (gnt[1]) last_q <= PORT_DMEM;
  end

endmodule

// File: rtl/ptw_resp_engine.sv
// Two-level page-table walker serving the imem and dmem TLBs over a
// single-beat memory port. One walk in flight; response pulses are registered.
module ptw_resp_engine
  import ptw_pkg::*;
#(
  parameter int VPN_W  = 20,
  parameter int PPN_W  = 20,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PPN_W-1:0]  ptbr,
  input  logic              io_imem_req_valid,
  output logic              io_imem_req_ready,
  input  logic [VPN_W-1:0]  io_imem_req_bits_vpn,
  input  logic              io_dmem_req_valid,
  output logic              io_dmem_req_ready,
  input  logic [VPN_W-1:0]  io_dmem_req_bits_vpn,
  output logic              io_imem_resp_valid,
  output logic              io_imem_resp_bits_error,
  output logic [31:0]       io_imem_resp_bits_ppn,
  output logic              io_dmem_resp_valid,
  output logic              io_dmem_resp_bits_error,
  output logic [31:0]       io_dmem_resp_bits_ppn,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
);

  localparam int IDX_W = VPN_W / 2;

  state_e           state_q, state_d;
  port_e            port_q;
  logic [VPN_W-1:0] vpn_q;
  logic [PPN_W-1:0] base_q;
  ptw_resp_t        imem_resp_q, dmem_resp_q;
  logic [1:0]       gnt;
  logic             accept;
  port_e            gnt_port;
  logic [IDX_W-1:0] idx;
  pte_t             pte;
  logic             fin, fin_err;
  logic [PPN_W-1:0] fin_ppn;

  assign pte = pte_t'(mem_resp_data);

  ptw_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_IDLE && !reset),
    .req   ({io_dmem_req_valid, io_imem_req_valid}),
    .gnt   (gnt)
  );

  assign io_imem_req_ready = gnt[0];
  assign io_dmem_req_ready = gnt[1];
  assign accept            = |gnt;
  assign gnt_port          = gnt[1] ? PORT_DMEM : PORT_IMEM;

  // Memory request decodes straight from state; base/idx are latched so the
  // address holds steady across a stalled handshake
  assign idx           = (state_q == ST_L0_REQ) ? vpn_q[IDX_W-1:0] : vpn_q[VPN_W-1:IDX_W];
  assign mem_req_valid = (state_q == ST_L1_REQ) || (state_q == ST_L0_REQ);
  assign mem_req_addr  = ADDR_W'({base_q, 12'b0}) | ADDR_W'({idx, 2'b00});

  assign io_imem_resp_valid      = imem_resp_q.valid;
  assign io_imem_resp_bits_error = imem_resp_q.error;
  assign io_imem_resp_bits_ppn   = imem_resp_q.ppn;
  assign io_dmem_resp_valid      = dmem_resp_q.valid;
  assign io_dmem_resp_bits_error = dmem_resp_q.error;
  assign io_dmem_resp_bits_ppn   = dmem_resp_q.ppn;

  // Walk sequencing and PTE decode; fin marks the cycle a result is known
  always_comb begin
    state_d = state_q;
    fin     = 1'b0;
    fin_err = 1'b0;
    fin_ppn = '0;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_L1_REQ;
      ST_L1_REQ:  if (mem_req_ready) state_d = ST_L1_WAIT;
      ST_L1_WAIT: if (mem_resp_valid) begin
        if (!pte.v) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (pte.leaf) begin
          // superpage: upper ppn from PTE, lower half passes the vpn through
          fin     = 1'b1;
          fin_ppn = {pte.ppn[PTE_PPN_W-1:IDX_W], vpn_q[IDX_W-1:0]};
        end else begin
          state_d = ST_L0_REQ;
        end
      end
      ST_L0_REQ:  if (mem_req_ready) state_d = ST_L0_WAIT;
      ST_L0_WAIT: if (mem_resp_valid) begin
        fin = 1'b1;
        if (!pte.v || !pte.leaf) fin_err = 1'b1;
        else                     fin_ppn = pte.ppn;
      end
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (fin) state_d = ST_RESP;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Request latch, next-level base, and one-cycle registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      vpn_q       <= '0;
      base_q      <= '0;
      port_q      <= PORT_IMEM;
      imem_resp_q <= '0;
      dmem_resp_q <= '0;
    end else begin
      imem_resp_q.valid <= 1'b0;
      dmem_resp_q.valid <= 1'b0;
      if (accept) begin
        vpn_q  <= gnt[1] ? io_dmem_req_bits_vpn : io_imem_req_bits_vpn;
        base_q <= ptbr;
        port_q <= gnt_port;
      end
      if (state_q == ST_L1_WAIT && mem_resp_valid && pte.v && !pte.leaf)
        base_q <= pte.ppn;
      if (fin) begin
        if (port_q == PORT_IMEM)
          imem_resp_q <= '{valid: 1'b1, error: fin_err, ppn: 32'(fin_ppn)};
        else
          dmem_resp_q <= '{valid: 1'b1, error: fin_err, ppn: 32'(fin_ppn)};
      end
    end
  end

endmodule

// File: tb/tb_ptw_resp_engine.sv
// Bench for ptw_resp_engine: memory responder, arithmetic walk model with a
// per-cycle compare process, and directed scenarios with literal expectations.
module tb_ptw_resp_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] ptbr;
  logic        io_imem_req_valid, io_imem_req_ready;
  logic [19:0] io_imem_req_bits_vpn;
  logic        io_dmem_req_valid, io_dmem_req_ready;
  logic [19:0] io_dmem_req_bits_vpn;
  logic        io_imem_resp_valid, io_imem_resp_bits_error;
  logic [31:0] io_imem_resp_bits_ppn;
  logic        io_dmem_resp_valid, io_dmem_resp_bits_error;
  logic [31:0] io_dmem_resp_bits_ppn;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  ptw_resp_engine dut (
    .clk(clk), .reset(reset), .ptbr(ptbr),
    .io_imem_req_valid(io_imem_req_valid), .io_imem_req_ready(io_imem_req_ready),
    .io_imem_req_bits_vpn(io_imem_req_bits_vpn),
    .io_dmem_req_valid(io_dmem_req_valid), .io_dmem_req_ready(io_dmem_req_ready),
    .io_dmem_req_bits_vpn(io_dmem_req_bits_vpn),
    .io_imem_resp_valid(io_imem_resp_valid), .io_imem_resp_bits_error(io_imem_resp_bits_error),
    .io_imem_resp_bits_ppn(io_imem_resp_bits_ppn),
    .io_dmem_resp_valid(io_dmem_resp_valid), .io_dmem_resp_bits_error(io_dmem_resp_bits_error),
    .io_dmem_resp_bits_ppn(io_dmem_resp_bits_ppn),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // ---------------- page-table memory ----------------
  logic [31:0] pmem [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    return pmem.exists(a) ? pmem[a] : 32'h0;
  endfunction

  // Reference walk, plain arithmetic on page sizes
  function automatic void walk(input logic [19:0] root, input logic [19:0] vpn,
                               output logic err, output logic [31:0] ppn,
                               output logic [31:0] a1, output logic [31:0] a0, output int nrd);
    logic [31:0] p1, p0;
    err = 1'b0; ppn = 32'h0; a0 = 32'h0; nrd = 1;
    a1 = root * 4096 + (vpn / 1024) * 4;
    p1 = rd(a1);
    if (p1[0] == 1'b0) err = 1'b1;
    else if (p1[1]) ppn = (p1 / (1 << 22)) * 1024 + vpn % 1024;
    else begin
      nrd = 2;
      a0 = (p1 / 4096) * 4096 + (vpn % 1024) * 4;
      p0 = rd(a0);
      if (p0[1:0] != 2'b11) err = 1'b1;
      else ppn = p0 / 4096;
    end
  endfunction

  // ---------------- memory responder ----------------
  typedef struct { int due; logic [31:0] addr; } pend_t;
  pend_t pend[$];
  int resp_delay = 0, stall_until = 0, stray_cyc = -1;

  initial begin
    pend_t e;
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0; mem_req_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        e.due = cyc + 1 + resp_delay; e.addr = mem_req_addr;
        pend.push_back(e);
      end
      @(posedge clk); #2;
      mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_resp_valid = 1'b1; mem_resp_data = rd(pend[0].addr);
        void'(pend.pop_front());
      end
      if (cyc == stray_cyc) begin mem_resp_valid = 1'b1; mem_resp_data = 32'h00800003; end
      mem_req_ready = (cyc >= stall_until);
    end
  end

  // ---------------- model state + compare process ----------------
  bit          busy = 0, chk_lat = 1, rst_prev = 0, prev_stall = 0;
  int          acc_cyc, exp_port, exp_lat, m_last = 1, stall_seen = 0, last_port = -1;
  logic        exp_err, last_err;
  logic [31:0] exp_ppn, last_ppn, prev_addr;
  logic [31:0] exp_addr[$], got_addr[$];
  int          acc_log[$];
  int          n_pulse[2] = '{0, 0};

  initial begin
    logic        e_err, v;
    logic [31:0] e_ppn, a1, a0;
    int          nrd, g, p;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_ready", {io_dmem_req_ready, io_imem_req_ready}, 0);
        if (rst_prev) begin
          check("rst_resp_valid", {io_dmem_resp_valid, io_imem_resp_valid}, 0);
          check("rst_resp_err", {io_dmem_resp_bits_error, io_imem_resp_bits_error}, 0);
          check("rst_imem_ppn", io_imem_resp_bits_ppn, 0);
          check("rst_dmem_ppn", io_dmem_resp_bits_ppn, 0);
          check("rst_mem_req_valid", mem_req_valid, 0);
        end
        busy = 0; exp_addr.delete(); m_last = 1; prev_stall = 0; rst_prev = 1;
      end else begin
        rst_prev = 0;
        // ready: none while a walk is in flight, round-robin choice otherwise
        if (busy) check("ready_while_busy", {io_dmem_req_ready, io_imem_req_ready}, 0);
        else begin
          check("idle_mem_req_valid", mem_req_valid, 0);
          if (io_imem_req_valid && io_dmem_req_valid) g = (m_last == 0) ? 1 : 0;
          else if (io_imem_req_valid) g = 0;
          else if (io_dmem_req_valid) g = 1;
          else g = -1;
          check("grant", {io_dmem_req_ready, io_imem_req_ready},
                (g == 1) ? 32'd2 : (g == 0) ? 32'd1 : 32'd0);
          p = -1;
          if (io_imem_req_valid && io_imem_req_ready) p = 0;
          else if (io_dmem_req_valid && io_dmem_req_ready) p = 1;
          if (p >= 0) begin
            walk(ptbr, p ? io_dmem_req_bits_vpn : io_imem_req_bits_vpn, e_err, e_ppn, a1, a0, nrd);
            exp_addr.delete();
            exp_addr.push_back(a1);
            if (nrd == 2) exp_addr.push_back(a0);
            exp_port = p; exp_err = e_err; exp_ppn = e_ppn;
            exp_lat = chk_lat ? ((nrd == 2) ? 5 : 3) : -1;
            busy = 1; acc_cyc = cyc; m_last = p; acc_log.push_back(p);
          end
        end
        // memory handshake: address order and stability under stall
        if (mem_req_valid) begin
          if (prev_stall) check("req_addr_stable", mem_req_addr, prev_addr);
          if (mem_req_ready) begin
            got_addr.push_back(mem_req_addr);
            if (exp_addr.size() > 0) check("mem_addr", mem_req_addr, exp_addr.pop_front());
            else check("unexpected_mem_req", 1, 0);
            prev_stall = 0;
          end else begin
            prev_stall = 1; prev_addr = mem_req_addr; stall_seen++;
          end
        end else begin
          if (prev_stall) check("req_valid_held", 0, 1);
          prev_stall = 0;
        end
        // response pulses
        for (int q = 0; q < 2; q++) begin
          v = q ? io_dmem_resp_valid : io_imem_resp_valid;
          if (v) begin
            n_pulse[q]++;
            last_port = q;
            last_err = q ? io_dmem_resp_bits_error : io_imem_resp_bits_error;
            last_ppn = q ? io_dmem_resp_bits_ppn : io_imem_resp_bits_ppn;
            if (busy && q == exp_port && acc_cyc != cyc) begin
              check("resp_err", last_err, exp_err);
              check("resp_ppn", last_ppn, exp_ppn);
              check("reads_done", exp_addr.size(), 0);
              if (exp_lat >= 0) check("latency", cyc - acc_cyc, exp_lat);
              busy = 0;
            end else check("spurious_resp", q, 32'hFFFF);
          end
        end
        if (busy && cyc - acc_cyc > 100) begin check("walk_timeout", 0, 1); busy = 0; end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] addr_at(input int i);
    return (got_addr.size() > i) ? got_addr[i] : 32'hDEADBEEF;
  endfunction

  function automatic int acc_at(input int i);
    return (acc_log.size() > i) ? acc_log[i] : -1;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (!busy) break;
    end
    step();
  endtask

  task automatic issue(input int port, input logic [19:0] vpn, input logic [19:0] ptbr_after);
    bit done = 0;
    if (port == 0) begin io_imem_req_valid = 1'b1; io_imem_req_bits_vpn = vpn; end
    else           begin io_dmem_req_valid = 1'b1; io_dmem_req_bits_vpn = vpn; end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if ((port == 0 && io_imem_req_ready) || (port == 1 && io_dmem_req_ready)) done = 1;
    end
    step();
    io_imem_req_valid = 1'b0; io_dmem_req_valid = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
    ptbr = ptbr_after;
    wait_idle();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n0, a0, pi, pd;
    reset = 1'b1; ptbr = 20'h0;
    io_imem_req_valid = 1'b0; io_imem_req_bits_vpn = 20'h0;
    io_dmem_req_valid = 1'b0; io_dmem_req_bits_vpn = 20'h0;
    pmem[32'h00080004] = 32'h00123001;
    pmem[32'h00123004] = 32'h00456003;
    pmem[32'h0008000C] = 32'h00800003;
    pmem[32'h00080010] = 32'h00200001;
    pmem[32'h0020001C] = 32'h00456001;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    ptbr = 20'h00080;

    // 1: two-level walk for imem
    n0 = got_addr.size(); pd = n_pulse[1];
    issue(0, 20'h00401, 20'h00080);
    check("t1_l1_addr", addr_at(n0), 32'h00080004);
    check("t1_l0_addr", addr_at(n0 + 1), 32'h00123004);
    check("t1_port", last_port, 0);
    check("t1_ppn", last_ppn, 32'h00000456);
    check("t1_err", last_err, 0);
    check("t1_no_dmem", n_pulse[1], pd);

    // 2: superpage for dmem
    n0 = got_addr.size(); pi = n_pulse[0];
    issue(1, 20'h00C05, 20'h00080);
    check("t2_reads", got_addr.size() - n0, 1);
    check("t2_l1_addr", addr_at(n0), 32'h0008000C);
    check("t2_port", last_port, 1);
    check("t2_ppn", last_ppn, 32'h00000805);
    check("t2_no_imem", n_pulse[0], pi);

    // 3: invalid L1, then non-leaf L0
    n0 = got_addr.size();
    issue(0, 20'h00802, 20'h00080);
    check("t3a_reads", got_addr.size() - n0, 1);
    check("t3a_err", last_err, 1);
    check("t3a_ppn", last_ppn, 0);
    issue(0, 20'h01007, 20'h00080);
    check("t3b_err", last_err, 1);
    check("t3b_ppn", last_ppn, 0);

    // 4: collisions right after reset alternate starting with imem
    reset = 1'b1; step(); step(); reset = 1'b0;
    a0 = acc_log.size();
    io_imem_req_valid = 1'b1; io_imem_req_bits_vpn = 20'h00C05;
    io_dmem_req_valid = 1'b1; io_dmem_req_bits_vpn = 20'h00C05;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #2;
      if (acc_log.size() >= a0 + 4) break;
    end
    step();
    io_imem_req_valid = 1'b0; io_dmem_req_valid = 1'b0;
    wait_idle();
    check("t4_grant0", acc_at(a0), 0);
    check("t4_grant1", acc_at(a0 + 1), 1);
    check("t4_grant2", acc_at(a0 + 2), 0);
    check("t4_grant3", acc_at(a0 + 3), 1);

    // 5: stalled memory, ptbr changed mid-walk, stray mem_resp in idle
    chk_lat = 0;
    n0 = got_addr.size(); a0 = stall_seen;
    stall_until = cyc + 7;
    issue(0, 20'h00401, 20'h00999);
    check("t5_stalled", (stall_seen - a0) >= 4, 1);
    check("t5_l1_addr", addr_at(n0), 32'h00080004);
    check("t5_l0_addr", addr_at(n0 + 1), 32'h00123004);
    check("t5_ppn", last_ppn, 32'h00000456);
    n0 = got_addr.size(); pi = n_pulse[0]; pd = n_pulse[1];
    stray_cyc = cyc + 2;
    repeat (6) step();
    check("t5_stray_reads", got_addr.size(), n0);
    check("t5_stray_pulses", n_pulse[0] + n_pulse[1], pi + pd);

    // 6: reset during L0_WAIT drops the walk
    ptbr = 20'h00080; resp_delay = 3;
    n0 = got_addr.size(); pi = n_pulse[0];
    io_imem_req_valid = 1'b1; io_imem_req_bits_vpn = 20'h00401;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (got_addr.size() >= n0 + 1) io_imem_req_valid = 1'b0;
      if (got_addr.size() >= n0 + 2) break;
    end
    step();
    reset = 1'b1; step(); step(); reset = 1'b0;
    io_imem_req_valid = 1'b0; resp_delay = 0;
    repeat (6) step();
    check("t6_no_resp", n_pulse[0], pi);
    check("t6_reads", got_addr.size() - n0, 2);
    chk_lat = 1;
    issue(0, 20'h00401, 20'h00080);
    check("t6_after_pulses", n_pulse[0], pi + 1);
    check("t6_after_ppn", last_ppn, 32'h00000456);
    check("t6_after_err", last_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
